// File: rtl/ula_exec_if.sv
// Valid/ready bus between the ula_ctrl stage, the execute ALU and its consumer.
// master = upstream/downstream environment, slave = the ALU.
interface ula_exec_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, alu_ctrl, op_a, op_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
endinterface

// File: rtl/ula_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, iterative 1-bit/cycle shifter,
// registered result with zero/overflow flags behind a valid/ready handshake.
module ula_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    ula_exec_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOR  = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_SLL  = 4'h8;
    localparam logic [3:0] OP_SRL  = 4'h9;
    localparam logic [3:0] OP_SRA  = 4'hA;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] work_r, result_r, shifted_s;
    logic [SHW-1:0]   count_r;
    logic [1:0]       shop_r, shop_s;
    logic             zero_r, ovf_r, out_valid_r;
    logic             in_ready_s, accept_s, is_shift_s, start_shift_s;
    logic [WIDTH:0]   calc_s;

    // Single-cycle datapath; shift codes only reach here with a zero amount, so they pass op_b.
    function automatic logic [WIDTH:0] alu_calc(input logic [3:0] ctrl,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic             ov;
        r  = a + b;
        ov = 1'b0;
        case (ctrl)
            OP_SUB: begin
                r  = a - b;
                ov = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL, OP_SRL, OP_SRA: r = b;
            default: begin
                r  = a + b;
                ov = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
        endcase
        return {ov, r};
    endfunction

    // Handshake, op decode, one-bit shift step and next-state selection.
    always_comb begin
        state_s    = state_r;
        in_ready_s = 1'b0;
        shop_s     = 2'd0;
        shifted_s  = work_r;
        case (state_r)
            IDLE:    in_ready_s = rst_n;
            DONE:    in_ready_s = rst_n & bus.out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s      = bus.in_valid & in_ready_s;
        is_shift_s    = (bus.alu_ctrl == OP_SLL) || (bus.alu_ctrl == OP_SRL) ||
                        (bus.alu_ctrl == OP_SRA);
        start_shift_s = accept_s && is_shift_s && (bus.shamt != {SHW{1'b0}});
        calc_s        = alu_calc(bus.alu_ctrl, bus.op_a, bus.op_b);
        case (bus.alu_ctrl)
            OP_SRL:  shop_s = 2'd1;
            OP_SRA:  shop_s = 2'd2;
            default: shop_s = 2'd0;
        endcase
        case (shop_r)
            2'd0:    shifted_s = {work_r[WIDTH-2:0], 1'b0};
            2'd1:    shifted_s = {1'b0, work_r[WIDTH-1:1]};
            default: shifted_s = {work_r[WIDTH-1], work_r[WIDTH-1:1]};
        endcase
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    state_s = start_shift_s ? SHIFT : DONE;
                end else if (state_r == DONE && bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = state_r;
                end
            end
            SHIFT: begin
                if (count_r == SHW'(1)) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State, shifter and result/flag registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            work_r      <= {WIDTH{1'b0}};
            count_r     <= {SHW{1'b0}};
            shop_r      <= 2'd0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            if (start_shift_s) begin
                work_r      <= bus.op_b;
                count_r     <= bus.shamt;
                shop_r      <= shop_s;
                out_valid_r <= 1'b0;
            end else if (accept_s) begin
                result_r    <= calc_s[WIDTH-1:0];
                zero_r      <= (calc_s[WIDTH-1:0] == {WIDTH{1'b0}});
                ovf_r       <= calc_s[WIDTH];
                out_valid_r <= 1'b1;
            end else if (state_r == SHIFT) begin
                work_r  <= shifted_s;
                count_r <= count_r - SHW'(1);
                if (count_r == SHW'(1)) begin
                    result_r    <= shifted_s;
                    zero_r      <= (shifted_s == {WIDTH{1'b0}});
                    ovf_r       <= 1'b0;
                    out_valid_r <= 1'b1;
                end
            end else if (state_r == DONE && bus.out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.zero      = zero_r;
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_ula_exec.sv
// Self-checking bench for ula_exec: directed scenarios plus randomized ops checked
// against an arithmetic reference model.
module tb_ula_exec;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ula_exec_if #(.WIDTH(32)) bus ();
    ula_exec #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // Reference: {overflow, result} from plain integer arithmetic.
    function automatic logic [32:0] model(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b, input logic [4:0] sh);
        longint    sa, sb, s;
        logic [31:0] r;
        logic      ov;
        sa = $signed(a);
        sb = $signed(b);
        ov = 1'b0;
        case (c)
            4'h1: begin s = sa - sb; r = s[31:0]; ov = (s != longint'($signed(r))); end
            4'h2: r = a & b;
            4'h3: r = a | b;
            4'h4: r = a ^ b;
            4'h5: r = ~(a | b);
            4'h6: r = (sa < sb) ? 32'd1 : 32'd0;
            4'h7: r = (a < b) ? 32'd1 : 32'd0;
            4'h8: r = b << sh;
            4'h9: r = b >> sh;
            4'hA: r = $signed(b) >>> sh;
            default: begin s = sa + sb; r = s[31:0]; ov = (s != longint'($signed(r))); end
        endcase
        return {ov, r};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh);
        int n;
        n = 0;
        bus.alu_ctrl = c;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.shamt    = sh;
        bus.in_valid = 1'b1;
        #1;
        while (!bus.in_ready && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_accept: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL wait_valid: out_valid=%b required 1 within 64 cycles", bus.out_valid);
        end
    endtask

    task automatic test_reset;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        bus.alu_ctrl  = 4'h0;
        bus.op_a      = 32'h1;
        bus.op_b      = 32'h2;
        bus.shamt     = 5'd0;
        repeat (3) begin
            tick();
            checks++;
            if ({bus.in_ready, bus.out_valid, bus.result} !== 34'd0) begin
                errors++;
                $display("FAIL reset_hold: in_ready=%b out_valid=%b result=%h required 0 0 0",
                         bus.in_ready, bus.out_valid, bus.result);
            end
        end
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        tick();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_add_sub;
        bus.out_ready = 1'b1;
        send(4'h0, 32'h7FFFFFFF, 32'h1, 5'd0);
        checks++;
        if ({bus.out_valid, bus.result, bus.overflow, bus.zero} !== {1'b1, 32'h80000000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_ovf: v=%b r=%h ov=%b z=%b required 1 80000000 1 0",
                     bus.out_valid, bus.result, bus.overflow, bus.zero);
        end
        send(4'h1, 32'd5, 32'd5, 5'd0);
        checks++;
        if ({bus.out_valid, bus.result, bus.overflow, bus.zero} !== {1'b1, 32'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL sub_zero: v=%b r=%h ov=%b z=%b required 1 0 0 1",
                     bus.out_valid, bus.result, bus.overflow, bus.zero);
        end
    endtask

    task automatic test_shift;
        int bad;
        bad = 0;
        send(4'hA, 32'h0, 32'h80000000, 5'd31);
        for (int i = 0; i < 31; i++) begin
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) bad++;
            bus.op_b = $urandom;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sra_busy: %0d busy cycles showed in_ready/out_valid high, required 0", bad);
        end
        checks++;
        if ({bus.out_valid, bus.result} !== {1'b1, 32'hFFFFFFFF}) begin
            errors++;
            $display("FAIL sra31: v=%b r=%h required 1 ffffffff", bus.out_valid, bus.result);
        end
        send(4'h8, 32'h0, 32'h1234, 5'd0);
        checks++;
        if ({bus.out_valid, bus.result} !== {1'b1, 32'h1234}) begin
            errors++;
            $display("FAIL sll0: v=%b r=%h required 1 00001234", bus.out_valid, bus.result);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] a, b;
        int bad;
        bad = 0;
        send(4'h6, 32'hFFFFFFFF, 32'h0, 5'd0);
        bus.out_ready = 1'b0;
        repeat (5) begin
            #1;
            if (bus.out_valid !== 1'b1 || bus.result !== 32'd1 || bus.in_ready !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL slt_hold: %0d stalled cycles lost result=1/out_valid or had in_ready, required 0", bad);
        end
        a = $urandom;
        b = $urandom;
        bus.alu_ctrl  = 4'h2;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL queued_ready: in_ready=%b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.result} !== {1'b1, a & b}) begin
            errors++;
            $display("FAIL queued_result: v=%b r=%h required 1 %h", bus.out_valid, bus.result, a & b);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  codes [4];
        logic [31:0] a, b;
        logic [32:0] exp;
        codes = '{4'h2, 4'h3, 4'h5, 4'h7};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom;
            exp = model(codes[i], a, b, 5'd0);
            bus.alu_ctrl = codes[i];
            bus.op_a     = a;
            bus.op_b     = b;
            bus.in_valid = 1'b1;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, bus.in_ready);
            end
            tick();
            checks++;
            if ({bus.out_valid, bus.result} !== {1'b1, exp[31:0]}) begin
                errors++;
                $display("FAIL b2b_result[%0d]: v=%b r=%h required 1 %h", i, bus.out_valid, bus.result, exp[31:0]);
            end
        end
        bus.in_valid = 1'b0;
        send(4'hC, 32'd2, 32'd3, 5'd0);
        checks++;
        if ({bus.result, bus.overflow} !== {32'd5, 1'b0}) begin
            errors++;
            $display("FAIL code_c: r=%h ov=%b required 00000005 0", bus.result, bus.overflow);
        end
    endtask

    task automatic test_random;
        logic [3:0]  c;
        logic [31:0] a, b;
        logic [4:0]  sh;
        logic [32:0] exp;
        int n, lat;
        bus.out_ready = 1'b1;
        repeat (60) begin
            c  = 4'($urandom_range(0, 15));
            a  = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : 32'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : 32'($urandom);
            sh = 5'($urandom_range(0, 31));
            exp = model(c, a, b, sh);
            lat = (c >= 4'h8 && c <= 4'hA && sh != 5'd0) ? int'(sh) : 0;
            send(c, a, b, sh);
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
            bus.shamt = 5'($urandom);
            wait_valid(n);
            checks++;
            if (n != lat) begin
                errors++;
                $display("FAIL rand_latency: code=%h sh=%0d latency=%0d required %0d", c, sh, n, lat);
            end
            checks++;
            if ({bus.result, bus.zero, bus.overflow} !== {exp[31:0], exp[31:0] == 32'd0, exp[32]}) begin
                errors++;
                $display("FAIL rand_result: code=%h a=%h b=%h sh=%0d r=%h z=%b ov=%b required %h %b %b",
                         c, a, b, sh, bus.result, bus.zero, bus.overflow, exp[31:0], exp[31:0] == 32'd0, exp[32]);
            end
        end
    endtask

    task automatic test_reset_mid_shift;
        logic [31:0] a, b;
        int bad;
        bad = 0;
        bus.out_ready = 1'b1;
        send(4'h9, 32'h0, 32'($urandom), 5'd20);
        repeat (9) begin
            if (bus.out_valid !== 1'b0) bad++;
            tick();
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.result} !== 34'd0) begin
            errors++;
            $display("FAIL midshift_reset: in_ready=%b v=%b r=%h required 0 0 0",
                     bus.in_ready, bus.out_valid, bus.result);
        end
        rst_n = 1'b1;
        repeat (25) begin
            if (bus.out_valid !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL midshift_no_output: out_valid high in %0d cycles, required 0", bad);
        end
        a = $urandom;
        b = $urandom;
        send(4'h0, a, b, 5'd0);
        checks++;
        if ({bus.out_valid, bus.result} !== {1'b1, a + b}) begin
            errors++;
            $display("FAIL after_reset_add: v=%b r=%h required 1 %h", bus.out_valid, bus.result, a + b);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
